fc_irq_arbiter: RTL and testbench

- Parametrised event-to-core interrupt arbiter for the fabric-controller core.
- Latches NB_IRQ event pulses as pending and selects one unmasked pending interrupt by fixed or round-robin priority.
- Presents the selection either as an id-based req/ack handshake or as one-hot fast-IRQ lines, with id remapping in both directions.
- Replaces the hard-coded single-remap id-to-fast conversion with a generic block that has explicit hold, retraction and drop accounting.

---
 rtl/fc_irq_arbiter.sv | 163 ++++++++++++++++
 tb/tb_fc_irq_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_irq_arbiter.sv
// Event-to-core interrupt arbiter for the fabric-controller core.
// Event pulses are latched as pending. One unmasked pending source is selected
// by fixed or round-robin priority and presented either as an id handshake or
// as one-hot fast-IRQ lines.
//
// Handshake: in REQ the request (irq_req_o/irq_id_o, or the one-hot
// irq_fast_o line) is held stable until the core returns a one-cycle irq_ack_i
// whose id (or fast line, translated back to an id) matches the current
// request. The request is also retracted without an ack when the source is
// masked or no longer pending. After a matching ack there is one GAP cycle in
// which all request outputs are low.
module fc_irq_arbiter #(
  parameter int NB_IRQ     = 32,
  parameter int ID_W       = 5,
  parameter int MODE       = 0,
  parameter int NB_FAST    = 15,
  parameter int REMAP_ID   = 26,
  parameter int REMAP_LINE = 10,
  parameter int RR_EN      = 0,
  parameter int CNT_W      = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NB_IRQ-1:0] events_i,
  input  logic [NB_IRQ-1:0] mask_i,
  output logic              irq_req_o,
  output logic [ID_W-1:0]   irq_id_o,
  output logic [NB_FAST-1:0] irq_fast_o,
  input  logic              irq_ack_i,
  input  logic [ID_W-1:0]   irq_ack_id_i,
  output logic [NB_IRQ-1:0] pending_o,
  output logic [CNT_W-1:0]  drop_cnt_o
);

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_e;

  state_e              state_q, state_d;
  logic [NB_IRQ-1:0]   pending_q, pending_d;
  logic [NB_IRQ-1:0]   ack_hit, elig, cand, cur_hot;
  logic [ID_W-1:0]     ack_id, cur_q, cur_d, ptr_q, ptr_d;
  logic [ID_W-1:0]     sel, sel_lo, sel_hi;
  logic                hi_found;
  logic [CNT_W-1:0]    drop_q, drop_d;
  logic                req_q, req_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [NB_FAST-1:0]  fast_q, fast_d;
  logic                cur_live, cur_acked;
  int                  cur_line;

  // Translate the acknowledge back into a source id (fast line -> id in MODE=1).
  always_comb begin
    ack_id = irq_ack_id_i;
    if (MODE == 1 && int'(irq_ack_id_i) == REMAP_LINE) ack_id = ID_W'(REMAP_ID);
  end

  // Per-source decode: ack hits, fast-line eligibility and current-request one-hot.
  always_comb begin
    ack_hit = '0;
    elig    = '0;
    cur_hot = '0;
    for (int k = 0; k < NB_IRQ; k++) begin
      ack_hit[k] = irq_ack_i && (int'(ack_id) == k);
      cur_hot[k] = (int'(cur_q) == k);
      if (MODE == 1) elig[k] = ((k < NB_FAST) && (k != REMAP_LINE)) || (k == REMAP_ID);
      else           elig[k] = 1'b1;
    end
  end

  // Pending set/clear (set wins) and saturating count of events that hit a pending source.
  always_comb begin
    pending_d = events_i | (pending_q & ~ack_hit);
    drop_d    = drop_q;
    if (|(events_i & pending_q & ~ack_hit) && (drop_q != {CNT_W{1'b1}}))
      drop_d = drop_q + CNT_W'(1);
  end

  assign cand      = pending_q & mask_i & elig;
  assign cur_live  = |(cur_hot & pending_q & mask_i);
  assign cur_acked = |(cur_hot & ack_hit);

  // Priority select: lowest candidate overall, or lowest at/after ptr with wrap.
  always_comb begin
    sel_lo   = '0;
    sel_hi   = '0;
    hi_found = 1'b0;
    for (int k = NB_IRQ - 1; k >= 0; k--) begin
      if (cand[k]) sel_lo = ID_W'(k);
      if (cand[k] && (k >= int'(ptr_q))) begin
        sel_hi   = ID_W'(k);
        hi_found = 1'b1;
      end
    end
    sel = (RR_EN == 1 && hi_found) ? sel_hi : sel_lo;
  end

  // Next-state logic and registered request outputs derived from the next state.
  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    ptr_d    = ptr_q;
    req_d    = 1'b0;
    id_d     = '0;
    fast_d   = '0;
    cur_line = 0;
    case (state_q)
      IDLE: begin
        if (|cand) begin
          cur_d   = sel;
          state_d = REQ;
        end
      end
      REQ: begin
        if (cur_acked) begin
          state_d = GAP;
          ptr_d   = (int'(cur_q) == NB_IRQ - 1) ? '0 : cur_q + ID_W'(1);
        end else if (!cur_live) begin
          state_d = IDLE;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    cur_line = (int'(cur_d) == REMAP_ID) ? REMAP_LINE : int'(cur_d);
    if (state_d == REQ) begin
      if (MODE == 0) begin
        req_d = 1'b1;
        id_d  = cur_d;
      end else begin
        for (int l = 0; l < NB_FAST; l++) fast_d[l] = (cur_line == l);
      end
    end
  end

  // State, pending, counter and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      pending_q <= '0;
      cur_q     <= '0;
      ptr_q     <= '0;
      drop_q    <= '0;
      req_q     <= 1'b0;
      id_q      <= '0;
      fast_q    <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      cur_q     <= cur_d;
      ptr_q     <= ptr_d;
      drop_q    <= drop_d;
      req_q     <= req_d;
      id_q      <= id_d;
      fast_q    <= fast_d;
    end
  end

  assign irq_req_o  = req_q;
  assign irq_id_o   = id_q;
  assign irq_fast_o = fast_q;
  assign pending_o  = pending_q;
  assign drop_cnt_o = drop_q;

endmodule

// File: tb/tb_fc_irq_arbiter.sv
// Testbench for fc_irq_arbiter: fixed-priority id mode, fast-line mode and
// round-robin id mode instances sharing clock and reset.
module tb_fc_irq_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // instance 0: MODE=0, RR_EN=0
  logic [31:0] ev0, mk0, pend0;
  logic        ack0, req0;
  logic [4:0]  aid0, id0;
  logic [14:0] fast0;
  logic [7:0]  drop0;
  // instance 1: MODE=1
  logic [31:0] ev1, mk1, pend1;
  logic        ack1, req1;
  logic [4:0]  aid1, id1;
  logic [14:0] fast1;
  logic [7:0]  drop1;
  // instance 2: MODE=0, RR_EN=1
  logic [31:0] ev2, mk2, pend2;
  logic        ack2, req2;
  logic [4:0]  aid2, id2;
  logic [14:0] fast2;
  logic [7:0]  drop2;

  fc_irq_arbiter #(.MODE(0), .RR_EN(0)) u0 (
    .clk_i(clk), .rst_i(rst), .events_i(ev0), .mask_i(mk0),
    .irq_req_o(req0), .irq_id_o(id0), .irq_fast_o(fast0),
    .irq_ack_i(ack0), .irq_ack_id_i(aid0), .pending_o(pend0), .drop_cnt_o(drop0));

  fc_irq_arbiter #(.MODE(1), .RR_EN(0)) u1 (
    .clk_i(clk), .rst_i(rst), .events_i(ev1), .mask_i(mk1),
    .irq_req_o(req1), .irq_id_o(id1), .irq_fast_o(fast1),
    .irq_ack_i(ack1), .irq_ack_id_i(aid1), .pending_o(pend1), .drop_cnt_o(drop1));

  fc_irq_arbiter #(.MODE(0), .RR_EN(1)) u2 (
    .clk_i(clk), .rst_i(rst), .events_i(ev2), .mask_i(mk2),
    .irq_req_o(req2), .irq_id_o(id2), .irq_fast_o(fast2),
    .irq_ack_i(ack2), .irq_ack_id_i(aid2), .pending_o(pend2), .drop_cnt_o(drop2));

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [4:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_n(input int n);
    repeat (n) step();
  endtask

  task automatic pulse_u0(input logic [31:0] e);
    ev0 = e; step(); ev0 = '0;
  endtask
  task automatic pulse_u1(input logic [31:0] e);
    ev1 = e; step(); ev1 = '0;
  endtask
  task automatic pulse_u2(input logic [31:0] e);
    ev2 = e; step(); ev2 = '0;
  endtask

  task automatic ack_u0(input logic [4:0] id);
    ack0 = 1'b1; aid0 = id; step(); ack0 = 1'b0; aid0 = '0;
  endtask
  task automatic ack_u1(input logic [4:0] id);
    ack1 = 1'b1; aid1 = id; step(); ack1 = 1'b0; aid1 = '0;
  endtask
  task automatic ack_u2(input logic [4:0] id);
    ack2 = 1'b1; aid2 = id; step(); ack2 = 1'b0; aid2 = '0;
  endtask

  // Bounded wait for a request on the selected instance.
  task automatic wait_req(input int inst, input string name);
    int c;
    bit seen;
    c = 0;
    seen = 1'b0;
    while (!seen && c < 12) begin
      case (inst)
        0:       seen = req0;
        1:       seen = |fast1;
        default: seen = req2;
      endcase
      if (!seen) begin
        step();
        c++;
      end
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: req=0 after %0d cycles, required req=1", name, c);
    end
  endtask

  // Drain every pending bit of instance 0 and let the FSM settle.
  task automatic clean_u0();
    mk0 = '1;
    for (int k = 0; k < 32; k++) if (pend0[k]) ack_u0(5'(k));
    step_n(4);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] ev;
    logic [31:0] mk;
    logic        exp_req;
    logic [4:0]  exp_id;
    logic [31:0] exp_pend;
  } vec_t;

  vec_t vt[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1);
  end

  initial begin
    vt[0] = '{ev: 32'h0000_0088, mk: 32'hFFFF_FFFF, exp_req: 1'b1, exp_id: 5'd3,  exp_pend: 32'h0000_0088};
    vt[1] = '{ev: 32'h0000_0001, mk: 32'hFFFF_FFFF, exp_req: 1'b1, exp_id: 5'd0,  exp_pend: 32'h0000_0001};
    vt[2] = '{ev: 32'h8000_0000, mk: 32'hFFFF_FFFF, exp_req: 1'b1, exp_id: 5'd31, exp_pend: 32'h8000_0000};
    vt[3] = '{ev: 32'h0000_00F0, mk: 32'hFFFF_FF4F, exp_req: 1'b1, exp_id: 5'd6,  exp_pend: 32'h0000_00F0};
    vt[4] = '{ev: 32'h0100_0000, mk: 32'h0000_0000, exp_req: 1'b0, exp_id: 5'd0,  exp_pend: 32'h0100_0000};
    vt[5] = '{ev: 32'hC000_0000, mk: 32'hFFFF_FFFF, exp_req: 1'b1, exp_id: 5'd30, exp_pend: 32'hC000_0000};
    vt[6] = '{ev: 32'h0003_0000, mk: 32'hFFFE_FFFF, exp_req: 1'b1, exp_id: 5'd17, exp_pend: 32'h0003_0000};

    rst = 1'b1;
    ev0 = '0; mk0 = '1; ack0 = 1'b0; aid0 = '0;
    ev1 = '0; mk1 = '1; ack1 = 1'b0; aid1 = '0;
    ev2 = '0; mk2 = '1; ack2 = 1'b0; aid2 = '0;
    step_n(3);
    check("rst_req0",  32'(req0),  32'h0);
    check("rst_id0",   32'(id0),   32'h0);
    check("rst_pend0", pend0,      32'h0);
    check("rst_drop0", 32'(drop0), 32'h0);
    check("rst_fast1", 32'(fast1), 32'h0);
    check("rst_req2",  32'(req2),  32'h0);
    rst = 1'b0;
    step();
    check("post_rst_req0", 32'(req0), 32'h0);

    // ---- table: fixed priority / masking in id mode ----
    for (int i = 0; i < 7; i++) begin
      mk0 = vt[i].mk;
      pulse_u0(vt[i].ev);
      check($sformatf("vec%0d_lat_req", i), 32'(req0), 32'h0);
      step();
      check($sformatf("vec%0d_req", i),  32'(req0),  32'(vt[i].exp_req));
      check($sformatf("vec%0d_id", i),   32'(id0),   32'(vt[i].exp_id));
      check($sformatf("vec%0d_pend", i), pend0,      vt[i].exp_pend);
      check($sformatf("vec%0d_drop", i), 32'(drop0), 32'h0);
      check($sformatf("vec%0d_fast", i), 32'(fast0), 32'h0);
      clean_u0();
      check($sformatf("vec%0d_clean_req", i),  32'(req0), 32'h0);
      check($sformatf("vec%0d_clean_pend", i), pend0,     32'h0);
    end

    // ---- ack, GAP, next request, hold ----
    mk0 = '1;
    pulse_u0(32'h88);
    step();
    check("seqA_id3", 32'(id0), 32'd3);
    ack_u0(5'd3);
    check("seqA_gap_req", 32'(req0), 32'h0);
    check("seqA_pend80",  pend0,     32'h80);
    wait_req(0, "seqA_wait7");
    check("seqA_id7", 32'(id0), 32'd7);
    pulse_u0(32'h2);
    check("hold_id7_a", 32'(id0), 32'd7);
    step_n(3);
    check("hold_id7_b", 32'(id0), 32'd7);
    check("hold_req",   32'(req0), 32'h1);
    check("hold_pend",  pend0,     32'h82);
    ack_u0(5'd7);
    check("hold_gap_req", 32'(req0), 32'h0);
    wait_req(0, "hold_wait1");
    check("hold_id1", 32'(id0), 32'd1);
    ack_u0(5'd1);
    step_n(3);
    check("seqA_end_pend", pend0, 32'h0);

    // ---- retraction by mask ----
    pulse_u0(32'h20);
    step();
    check("retr_id5", 32'(id0), 32'd5);
    mk0 = ~32'h20;
    step();
    check("retr_req",  32'(req0),  32'h0);
    check("retr_pend", pend0,      32'h20);
    check("retr_drop", 32'(drop0), 32'h0);
    step_n(3);
    check("retr_still_low", 32'(req0), 32'h0);
    mk0 = '1;
    wait_req(0, "retr_wait5");
    check("retr_reid5", 32'(id0), 32'd5);
    ack_u0(5'd5);
    step_n(3);

    // ---- same-cycle set and ack on id 9 ----
    pulse_u0(32'h200);
    step();
    check("sc_id9", 32'(id0), 32'd9);
    ev0 = 32'h200; ack0 = 1'b1; aid0 = 5'd9;
    step();
    ev0 = '0; ack0 = 1'b0; aid0 = '0;
    check("sc_pend9", pend0,      32'h200);
    check("sc_gap",   32'(req0),  32'h0);
    check("sc_drop",  32'(drop0), 32'h0);
    wait_req(0, "sc_wait9");
    check("sc_reid9", 32'(id0), 32'd9);
    ack_u0(5'd9);
    step_n(3);
    check("sc_end_pend", pend0, 32'h0);

    // ---- drop counter: multi-drop cycle and saturation ----
    pulse_u0(32'h3000);
    step();
    check("drop_start", 32'(drop0), 32'h0);
    pulse_u0(32'h3000);
    check("drop_multi", 32'(drop0), 32'd1);
    ev0 = 32'h1000;
    step_n(9);
    check("drop_ten", 32'(drop0), 32'd10);
    step_n(290);
    ev0 = '0;
    check("drop_sat", 32'(drop0), 32'd255);
    step();
    check("drop_sat_hold", 32'(drop0), 32'd255);
    check("drop_req_id12", 32'(id0),   32'd12);

    // ---- fast-line mode with remap ----
    pulse_u1(32'h0400_0000);
    step();
    check("fast_remap",  32'(fast1), 32'h0400);
    check("fast_req_tie", 32'(req1), 32'h0);
    check("fast_id_tie",  32'(id1),  32'h0);
    ack_u1(5'd10);
    check("fast_pend26_clr", pend1,     32'h0);
    check("fast_gap",        32'(fast1), 32'h0);
    step_n(3);
    pulse_u1(32'h0010_0400);
    step_n(4);
    check("fast_inelig", 32'(fast1), 32'h0);
    check("fast_inelig_pend", pend1, 32'h0010_0400);
    pulse_u1(32'h8);
    step();
    check("fast_line3", 32'(fast1), 32'h0008);
    ack_u1(5'd3);
    step_n(3);
    check("fast_after3_pend", pend1, 32'h0010_0400);
    ack_u1(5'd10);
    check("fast_ack10_to26", pend1,     32'h0010_0400);
    check("fast_quiet",      32'(fast1), 32'h0);

    // ---- round robin ----
    exp_q = {5'd2, 5'd4, 5'd6, 5'd2};
    pulse_u2(32'h54);
    for (int r = 0; r < 4; r++) begin
      logic [4:0] e;
      e = exp_q.pop_front();
      wait_req(2, $sformatf("rr%0d_wait", r));
      check($sformatf("rr%0d_id", r), 32'(id2), 32'(e));
      ack_u2(e);
      pulse_u2(32'h1 << e);
    end
    check("rr_queue_empty", 32'(exp_q.size()), 32'h0);

    // ---- asynchronous reset during REQ ----
    #2;
    rst = 1'b1;
    #1;
    check("arst_req0",  32'(req0),  32'h0);
    check("arst_id0",   32'(id0),   32'h0);
    check("arst_pend0", pend0,      32'h0);
    check("arst_drop0", 32'(drop0), 32'h0);
    check("arst_fast1", 32'(fast1), 32'h0);
    check("arst_pend2", pend2,      32'h0);
    step_n(2);
    rst = 1'b0;
    step_n(5);
    check("post_arst_req0",  32'(req0), 32'h0);
    check("post_arst_pend0", pend0,     32'h0);
    pulse_u0(32'h10);
    step();
    check("post_arst_new_req", 32'(req0), 32'h1);
    check("post_arst_new_id",  32'(id0),  32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
